// File: rtl/vec3_transform_if.sv
// Handshake and matrix-load bundle for vec3_transform.
interface vec3_transform_if #(
    parameter int unsigned WIDTH = 32
);
    logic                    mat_we;
    logic [3:0]              mat_addr;
    logic signed [WIDTH-1:0] mat_data;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_x, in_y, in_z;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_x, out_y, out_z;
    logic                    busy;

    modport master (
        output mat_we, mat_addr, mat_data, in_valid, in_x, in_y, in_z, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_z, busy
    );

    modport slave (
        input  mat_we, mat_addr, mat_data, in_valid, in_x, in_y, in_z, out_ready,
        output in_ready, out_valid, out_x, out_y, out_z, busy
    );
endinterface

// File: rtl/vec3_transform.sv
// Programmable 3x3 matrix-vector transform, out = M * v, built around one
// time-shared 3-stage dot-product pipeline (dotProduct_3, defined first).

module dotProduct_3 #(
    parameter int unsigned FIXED_POINT = 1,
    parameter int unsigned WIDTH       = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic signed [WIDTH-1:0] x0,
    input  logic signed [WIDTH-1:0] x1,
    input  logic signed [WIDTH-1:0] x2,
    input  logic signed [WIDTH-1:0] y0,
    input  logic signed [WIDTH-1:0] y1,
    input  logic signed [WIDTH-1:0] y2,
    output logic signed [WIDTH-1:0] result
);
    localparam int unsigned W2    = 2 * WIDTH;
    localparam int unsigned Shift = (FIXED_POINT != 0) ? WIDTH / 2 : 0;

    logic signed [W2-1:0]    prod0, prod1, prod2;
    logic signed [WIDTH-1:0] p0_q, p1_q, p2_q, s01_q, p2b_q, result_q;

    always_comb begin
        prod0 = W2'(x0) * W2'(y0);
        prod1 = W2'(x1) * W2'(y1);
        prod2 = W2'(x2) * W2'(y2);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            p0_q     <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
            s01_q    <= '0;
            p2b_q    <= '0;
            result_q <= '0;
        end else begin
            p0_q     <= WIDTH'(prod0 >>> Shift);
            p1_q     <= WIDTH'(prod1 >>> Shift);
            p2_q     <= WIDTH'(prod2 >>> Shift);
            s01_q    <= p0_q + p1_q;
            p2b_q    <= p2_q;
            result_q <= s01_q + p2b_q;
        end
    end

    assign result = result_q;
endmodule

module vec3_transform #(
    parameter int unsigned FIXED_POINT = 1,
    parameter int unsigned WIDTH       = 32
) (
    input logic             clk_in,
    input logic             rst_in,
    vec3_transform_if.slave bus
);
    localparam logic signed [WIDTH-1:0] One =
        (FIXED_POINT != 0) ? (WIDTH'(1) << (WIDTH / 2)) : WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              row_q, row_d;
    logic signed [WIDTH-1:0] mat_q [9];
    logic signed [WIDTH-1:0] vx_q, vy_q, vz_q;
    logic signed [WIDTH-1:0] dp_x0, dp_x1, dp_x2, dp_y0, dp_y1, dp_y2, dp_result;
    logic [2:0]              tag_vld_q;
    logic [1:0]              tag_row_q [3];
    logic signed [WIDTH-1:0] out_x_q, out_y_q, out_z_q;
    logic                    issue, accept, mat_wr;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        issue   = 1'b0;
        accept  = 1'b0;
        dp_x0   = '0;
        dp_x1   = '0;
        dp_x2   = '0;
        dp_y0   = '0;
        dp_y1   = '0;
        dp_y2   = '0;
        mat_wr  = (state_q == StIdle) && bus.mat_we && (bus.mat_addr <= 4'd8);
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    row_d   = 2'd0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                issue = 1'b1;
                dp_y0 = vx_q;
                dp_y1 = vy_q;
                dp_y2 = vz_q;
                case (row_q)
                    2'd0: begin
                        dp_x0 = mat_q[0];
                        dp_x1 = mat_q[1];
                        dp_x2 = mat_q[2];
                    end
                    2'd1: begin
                        dp_x0 = mat_q[3];
                        dp_x1 = mat_q[4];
                        dp_x2 = mat_q[5];
                    end
                    default: begin
                        dp_x0 = mat_q[6];
                        dp_x1 = mat_q[7];
                        dp_x2 = mat_q[8];
                    end
                endcase
                row_d = row_q + 2'd1;
                if (row_q == 2'd2) state_d = StDrain;
            end
            // Leave once the last row is being captured on this edge.
            StDrain: begin
                if (tag_vld_q[2] && (tag_row_q[2] == 2'd2)) state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= StIdle;
            row_q     <= 2'd0;
            vx_q      <= '0;
            vy_q      <= '0;
            vz_q      <= '0;
            tag_vld_q <= '0;
            for (int i = 0; i < 3; i++) tag_row_q[i] <= 2'd0;
            for (int i = 0; i < 9; i++) mat_q[i] <= (i % 4 == 0) ? One : '0;
            out_x_q   <= '0;
            out_y_q   <= '0;
            out_z_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            if (accept) begin
                vx_q <= bus.in_x;
                vy_q <= bus.in_y;
                vz_q <= bus.in_z;
            end
            if (mat_wr) mat_q[bus.mat_addr] <= bus.mat_data;
            // Tag tracks each issued row through the pipeline's three stages.
            tag_vld_q    <= {tag_vld_q[1:0], issue};
            tag_row_q[0] <= row_q;
            tag_row_q[1] <= tag_row_q[0];
            tag_row_q[2] <= tag_row_q[1];
            if (tag_vld_q[2]) begin
                case (tag_row_q[2])
                    2'd0:    out_x_q <= dp_result;
                    2'd1:    out_y_q <= dp_result;
                    default: out_z_q <= dp_result;
                endcase
            end
        end
    end

    dotProduct_3 #(
        .FIXED_POINT(FIXED_POINT),
        .WIDTH      (WIDTH)
    ) u_dot (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .x0    (dp_x0),
        .x1    (dp_x1),
        .x2    (dp_x2),
        .y0    (dp_y0),
        .y1    (dp_y1),
        .y2    (dp_y2),
        .result(dp_result)
    );

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_x     = out_x_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_z     = out_z_q;
endmodule

// File: tb/tb_vec3_transform.sv
// Scoreboard bench for vec3_transform: a fixed-point and an integer instance
// share clock and reset; results are checked against a reference model.
module tb_vec3_transform;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vec3_transform_if #(.WIDTH(W)) fx_if ();
    vec3_transform_if #(.WIDTH(W)) ix_if ();

    vec3_transform #(.FIXED_POINT(1), .WIDTH(W)) u_fx (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (fx_if)
    );

    vec3_transform #(.FIXED_POINT(0), .WIDTH(W)) u_ix (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (ix_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    logic prev_ov = 1'b0;

    logic [31:0] fx_mat [9];
    logic [31:0] ix_mat [9];
    logic [95:0] fx_q [$];
    logic [95:0] ix_q [$];
    logic [95:0] snap;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] model(input logic [31:0] m [9],
                                          input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z, input bit fp);
        logic [31:0]        v [3];
        logic [31:0]        r [3];
        logic signed [63:0] p;
        v[0] = x;
        v[1] = y;
        v[2] = z;
        for (int i = 0; i < 3; i++) begin
            r[i] = '0;
            for (int j = 0; j < 3; j++) begin
                p = 64'($signed(m[3*i+j])) * 64'($signed(v[j]));
                if (fp) p = p >>> 16;
                r[i] = r[i] + p[31:0];
            end
        end
        return {r[0], r[1], r[2]};
    endfunction

    task automatic set_identity();
        for (int i = 0; i < 9; i++) begin
            fx_mat[i] = (i % 4 == 0) ? 32'h0001_0000 : 32'h0;
            ix_mat[i] = (i % 4 == 0) ? 32'h1 : 32'h0;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitors sample on the falling edge; stimulus changes just after rising edges.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            check("busy", 96'(fx_if.busy), 96'(!fx_if.in_ready));
            if (fx_if.in_valid && fx_if.in_ready) accept_cyc = cyc + 1;
            if (fx_if.out_valid && !prev_ov) check("latency", 96'(cyc - accept_cyc), 96'd6);
            if (fx_if.out_valid && fx_if.out_ready) begin
                if (fx_q.size() == 0) check("fx_spurious", 96'd1, 96'd0);
                else check("fx_out", {fx_if.out_x, fx_if.out_y, fx_if.out_z}, fx_q.pop_front());
            end
            prev_ov = fx_if.out_valid;
            if (ix_if.out_valid && ix_if.out_ready) begin
                if (ix_q.size() == 0) check("ix_spurious", 96'd1, 96'd0);
                else check("ix_out", {ix_if.out_x, ix_if.out_y, ix_if.out_z}, ix_q.pop_front());
            end
        end
    end

    task automatic fx_write(input logic [3:0] a, input logic [31:0] d, input bit honoured);
        @(posedge clk); #1;
        fx_if.mat_we   = 1'b1;
        fx_if.mat_addr = a;
        fx_if.mat_data = d;
        @(posedge clk); #1;
        fx_if.mat_we = 1'b0;
        if (honoured) fx_mat[a] = d;
    endtask

    task automatic fx_send_exp(input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] z, input logic [95:0] exp);
        @(posedge clk); #1;
        fx_if.in_valid = 1'b1;
        fx_if.in_x     = x;
        fx_if.in_y     = y;
        fx_if.in_z     = z;
        for (int i = 0; i < 40; i++) begin
            if (fx_if.in_ready) begin
                fx_q.push_back(exp);
                @(posedge clk); #1;
                fx_if.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("fx_accept_timeout", 96'd0, 96'd1);
        fx_if.in_valid = 1'b0;
    endtask

    task automatic fx_send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        fx_send_exp(x, y, z, model(fx_mat, x, y, z, 1'b1));
    endtask

    task automatic fx_drain();
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (fx_q.size() == 0) return;
        end
        check("fx_drain_timeout", 96'(fx_q.size()), 96'd0);
        fx_q.delete();
    endtask

    task automatic ix_write(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        ix_if.mat_we   = 1'b1;
        ix_if.mat_addr = a;
        ix_if.mat_data = d;
        @(posedge clk); #1;
        ix_if.mat_we = 1'b0;
        ix_mat[a]    = d;
    endtask

    task automatic ix_run(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                          input logic [95:0] exp);
        @(posedge clk); #1;
        ix_if.in_valid = 1'b1;
        ix_if.in_x     = x;
        ix_if.in_y     = y;
        ix_if.in_z     = z;
        check("ix_in_ready", 96'(ix_if.in_ready), 96'd1);
        ix_q.push_back(exp);
        @(posedge clk); #1;
        ix_if.in_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (ix_q.size() == 0) return;
        end
        check("ix_drain_timeout", 96'(ix_q.size()), 96'd0);
        ix_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] rx, ry, rz;
        fx_if.mat_we = 1'b0; fx_if.mat_addr = '0; fx_if.mat_data = '0;
        fx_if.in_valid = 1'b0; fx_if.in_x = '0; fx_if.in_y = '0; fx_if.in_z = '0;
        fx_if.out_ready = 1'b1;
        ix_if.mat_we = 1'b0; ix_if.mat_addr = '0; ix_if.mat_data = '0;
        ix_if.in_valid = 1'b0; ix_if.in_x = '0; ix_if.in_y = '0; ix_if.in_z = '0;
        ix_if.out_ready = 1'b1;
        set_identity();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready", 96'(fx_if.in_ready), 96'd1);
        check("rst_out_valid", 96'(fx_if.out_valid), 96'd0);
        check("rst_busy", 96'(fx_if.busy), 96'd0);
        check("rst_outs", {fx_if.out_x, fx_if.out_y, fx_if.out_z}, 96'd0);

        // Identity after reset
        fx_send_exp(32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000,
                    {32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000});
        fx_drain();

        // Programmed matrix: rows (1,2,3), (0,-1,0), (0.5,0,0)
        fx_write(4'd0, 32'h0001_0000, 1'b1);
        fx_write(4'd1, 32'h0002_0000, 1'b1);
        fx_write(4'd2, 32'h0003_0000, 1'b1);
        fx_write(4'd3, 32'h0, 1'b1);
        fx_write(4'd4, 32'hFFFF_0000, 1'b1);
        fx_write(4'd5, 32'h0, 1'b1);
        fx_write(4'd6, 32'h0000_8000, 1'b1);
        fx_write(4'd7, 32'h0, 1'b1);
        fx_write(4'd8, 32'h0, 1'b1);
        fx_send_exp(32'h0002_0000, 32'h0003_0000, 32'h0004_0000,
                    {32'h0014_0000, 32'hFFFD_0000, 32'h0001_0000});
        fx_drain();

        // Backpressure, with a second vector waiting
        fx_if.out_ready = 1'b0;
        fx_send(32'h0001_8000, 32'hFFFE_0000, 32'h0000_4000);
        for (int i = 0; i < 20 && !fx_if.out_valid; i++) begin
            @(posedge clk); #1;
        end
        check("bp_ov_rise", 96'(fx_if.out_valid), 96'd1);
        snap = {fx_if.out_x, fx_if.out_y, fx_if.out_z};
        fx_if.in_valid = 1'b1;
        fx_if.in_x = 32'h0000_1000; fx_if.in_y = 32'h0003_0000; fx_if.in_z = 32'hFFFF_8000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_ov_hold", 96'(fx_if.out_valid), 96'd1);
            check("bp_out_hold", {fx_if.out_x, fx_if.out_y, fx_if.out_z}, snap);
            check("bp_in_ready", 96'(fx_if.in_ready), 96'd0);
        end
        fx_if.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", 96'(fx_if.in_ready), 96'd1);
        check("bp_release_ov", 96'(fx_if.out_valid), 96'd0);
        fx_q.push_back(model(fx_mat, 32'h0000_1000, 32'h0003_0000, 32'hFFFF_8000, 1'b1));
        @(posedge clk); #1;
        fx_if.in_valid = 1'b0;
        check("bp_second_accepted", 96'(fx_if.busy), 96'd1);
        fx_drain();

        // Write during ISSUE is dropped; the same write in IDLE lands
        fx_send(32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        fx_write(4'd0, 32'h0005_0000, 1'b0);
        fx_drain();
        fx_send(32'h0002_0000, 32'h0001_0000, 32'h0000_0000);
        fx_drain();
        fx_write(4'd9, 32'h1234_5678, 1'b0);
        fx_write(4'd0, 32'h0005_0000, 1'b1);
        fx_send(32'h0002_0000, 32'h0001_0000, 32'h0000_0000);
        fx_drain();

        // Write and accept in the same IDLE cycle
        @(posedge clk); #1;
        fx_if.mat_we = 1'b1; fx_if.mat_addr = 4'd4; fx_if.mat_data = 32'h0003_0000;
        fx_if.in_valid = 1'b1;
        fx_if.in_x = 32'h0001_0000; fx_if.in_y = 32'h0002_0000; fx_if.in_z = 32'h0001_0000;
        check("wa_in_ready", 96'(fx_if.in_ready), 96'd1);
        fx_mat[4] = 32'h0003_0000;
        fx_q.push_back(model(fx_mat, 32'h0001_0000, 32'h0002_0000, 32'h0001_0000, 1'b1));
        @(posedge clk); #1;
        fx_if.mat_we = 1'b0;
        fx_if.in_valid = 1'b0;
        fx_drain();

        // Random matrix updates and vectors
        for (int i = 0; i < 5; i++) begin
            fx_write(4'($urandom_range(0, 8)), $urandom, 1'b1);
            rx = $urandom; ry = $urandom; rz = $urandom;
            fx_send(rx, ry, rz);
            fx_drain();
        end

        // Reset one cycle after accept
        fx_send(32'h0001_0000, 32'h0002_0000, 32'h0003_0000);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fx_q.delete();
        set_identity();
        check("mid_rst_in_ready", 96'(fx_if.in_ready), 96'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("mid_rst_no_ov", 96'(fx_if.out_valid), 96'd0);
        end
        fx_send_exp(32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                    {32'h0001_0000, 32'h0002_0000, 32'h0003_0000});
        fx_drain();

        // Integer mode with two's-complement wrap
        ix_write(4'd0, 32'h7FFF_FFFF);
        ix_write(4'd1, 32'h0000_0001);
        ix_write(4'd2, 32'h0000_0000);
        ix_run(32'h1, 32'h1, 32'h0, {32'h8000_0000, 32'h0000_0001, 32'h0000_0000});
        ix_write(4'd5, 32'hFFFF_FFFD);
        ix_run(32'hFFFF_FFFE, 32'h0000_0007, 32'h0000_0004,
               model(ix_mat, 32'hFFFF_FFFE, 32'h0000_0007, 32'h0000_0004, 1'b0));

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
